// File: rtl/afifo_pkg.sv
// Shared definitions for the asynchronous FIFO read/write side buffers.
package afifo_pkg;

   localparam int AFIFO_RD_BUF_DEPTH = 3;

   typedef logic [1:0] afifo_idx_t;

   // Advance a circular buffer index, wrapping from the last entry back to 0.
   function automatic afifo_idx_t afifo_idx_next(input afifo_idx_t idx);
      return (idx == afifo_idx_t'(AFIFO_RD_BUF_DEPTH - 1)) ? afifo_idx_t'(0) : afifo_idx_t'(idx + 2'd1);
   endfunction

endpackage

// File: rtl/afifo_obuf.sv
// Three-entry circular output buffer: push at the tail, pop the head when the
// consumer is ready, sticky error if a push finds no room.
module afifo_obuf
   import afifo_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          rclk,
   input  logic          rrst_n,
   input  logic          srst,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          ready,
   output logic          valid,
   output logic [DW-1:0] rdata,
   output logic [1:0]    cnt,
   output logic          err
);

   localparam logic [1:0] CNT_FULL = 2'(AFIFO_RD_BUF_DEPTH);

   logic [DW-1:0] mem_q [AFIFO_RD_BUF_DEPTH];
   logic [DW-1:0] mem_d [AFIFO_RD_BUF_DEPTH];
   afifo_idx_t    rd_idx_q, rd_idx_d;
   afifo_idx_t    wr_idx_q, wr_idx_d;
   logic [1:0]    cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          full;
   logic          pop;
   logic          do_push;

   // Next-state for storage, indices, occupancy and the overflow flag.
   always_comb begin
      // NOTE: every signal gets its default first, so no path can leave one unassigned and infer a latch.
      mem_d    = mem_q;
      rd_idx_d = rd_idx_q;
      wr_idx_d = wr_idx_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      full     = (cnt_q == CNT_FULL);
      pop      = (cnt_q != 2'd0) & ready;
      do_push  = push & (~full | pop);
      if (srst) begin
         // Storage is left alone: only the bookkeeping is cleared, which hides it.
         rd_idx_d = '0;
         wr_idx_d = '0;
         cnt_d    = '0;
         err_d    = 1'b0;
      end else begin
         if (do_push) begin
            mem_d[wr_idx_q] = wdata;
            wr_idx_d        = afifo_idx_next(wr_idx_q);
         end
         if (pop) begin
            rd_idx_d = afifo_idx_next(rd_idx_q);
         end
         case ({do_push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
         endcase
         if (push & full & ~pop) begin
            err_d = 1'b1;
         end
      end
   end

   // Buffer state registers.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         // NOTE: these three words are reset on purpose so the head reads 0 out of reset; a true RAM array would not be.
         for (int i = 0; i < AFIFO_RD_BUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_idx_q <= '0;
         wr_idx_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         mem_q    <= mem_d;
         rd_idx_q <= rd_idx_d;
         wr_idx_q <= wr_idx_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   assign valid = (cnt_q != 2'd0);
   assign rdata = mem_q[rd_idx_q];
   assign cnt   = cnt_q;
   assign err   = err_q;

endmodule

// File: rtl/afifo_rdout.sv
// Read-side consumer of the async FIFO: issues reads while there is guaranteed
// room, captures the RAM word one cycle later, and presents a FWFT stream.
module afifo_rdout
   import afifo_pkg::*;
#(
   parameter int DW      = 32,
   parameter int RAM_LAT = 1
) (
   input  logic          rclk,
   input  logic          rrst_n,
   input  logic          rsrst,
   input  logic          rempty,
   input  logic [DW-1:0] ram_rdata,
   output logic          rinc,
   output logic          dout_valid,
   output logic [DW-1:0] dout_data,
   input  logic          dout_ready,
   output logic [1:0]    dout_lvl,
   output logic          dout_err
);

   generate
      if (RAM_LAT != 1) begin : g_ram_lat_check
         $error("afifo_rdout: only RAM_LAT=1 is supported");
      end
   endgenerate

   logic       pend_q, pend_d;
   logic       rinc_c;
   logic [1:0] cnt;
   logic [2:0] level;

   // Issue a read only when buffered plus in-flight words leave room; uses
   // registered state only, so dout_ready never reaches rinc combinationally.
   always_comb begin
      level  = {1'b0, cnt} + {2'b00, pend_q};
      rinc_c = rrst_n & ~rsrst & ~rempty & (level < 3'(AFIFO_RD_BUF_DEPTH));
      pend_d = rinc_c;
   end

   // In-flight read marker: the RAM word lands on ram_rdata the cycle after an issue.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         pend_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
      end
   end

   afifo_obuf #(
      .DW (DW)
   ) u_obuf (
      .rclk   (rclk),
      .rrst_n (rrst_n),
      .srst   (rsrst),
      .push   (pend_q),
      .wdata  (ram_rdata),
      .ready  (dout_ready),
      .valid  (dout_valid),
      .rdata  (dout_data),
      .cnt    (cnt),
      .err    (dout_err)
   );

   assign rinc     = rinc_c;
   assign dout_lvl = cnt;

endmodule
